number_output_convertor: RTL and testbench

Serialises a 64-bit unsigned binary result into its ASCII decimal representation, one byte per handshake, most significant digit first, with leading zeros suppressed. It is the output-side counterpart of the numbers input converter: the AOC datapath hands it a finished 64-bit result, and the bytes go to the program output stream. Conversion uses iterative shift-add-3 (double-dabble) into a 20-digit BCD register, then leading-zero skipping, then emission.

---
 rtl/number_output_convertor_if.sv | 24 ++
 rtl/number_output_convertor.sv | 181 ++++++++++++++++++
 tb/tb_number_output_convertor.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/number_output_convertor_if.sv
// Stream bundle for number_output_convertor: a 64-bit binary value in,
// ASCII decimal bytes out, plus a busy flag.
// master: the side that supplies numbers and consumes bytes.
// slave:  the converter itself.
interface number_output_convertor_if;
  logic [63:0] Number_1;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  modport master (
    output Number_1, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy
  );

  modport slave (
    input  Number_1, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/number_output_convertor.sv
// number_output_convertor: turns a 64-bit unsigned value into ASCII decimal,
// most significant digit first, with leading zeros suppressed.
// Double-dabble into 20 BCD digits (64 cycles), then skip leading zero
// digits one per cycle, then emit one byte per out_valid/out_ready handshake.
// Optional feature macro: NUMOUT_NEWLINE_EN appends a 0x0A terminator byte
// which then carries out_last instead of the final digit.
module number_output_convertor #(
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic                           clk,
  input  logic                           rst,
  number_output_convertor_if.slave       bus
);

  // Identification only; no sub-instances consume them.
  localparam int    unused_uuid = UUID;
  localparam string unused_name = NAME;

`ifdef NUMOUT_NEWLINE_EN
  localparam bit NL_EN = 1'b1;
`else
  localparam bit NL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_SKIP    = 3'd2,
    S_EMIT    = 3'd3
`ifdef NUMOUT_NEWLINE_EN
    ,
    S_NEWLINE = 3'd4
`endif
  } state_t;

  state_t      state_q;
  logic [63:0] bin_q;
  logic [79:0] bcd_q;
  logic [6:0]  cnt_q;
  logic [4:0]  ndig_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic [7:0]  out_data_q;
  logic        busy_q;

  // Single BCD digit correction: add 3 when >=5, no carry out of the digit.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // One double-dabble step: correct every digit, then shift the whole BCD
  // register left by one with lsb entering digit 0. The bit leaving digit 19
  // is always zero for 64-bit inputs, so it is simply dropped.
  function automatic logic [79:0] bcd_step(input logic [79:0] v, input logic lsb);
    logic [79:0] r;
    logic [3:0]  a;
    logic        c;
    r = '0;
    c = lsb;
    for (int i = 0; i < 20; i++) begin
      a          = add3(v[4*i +: 4]);
      r[4*i +: 4] = {a[2:0], c};
      c          = a[3];
    end
    return r;
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  // out_last rides on the final digit only when no newline terminator follows.
  function automatic logic is_last(input logic [4:0] n);
    return (n == 5'd1) & ~NL_EN;
  endfunction

  // Control FSM and datapath with registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ndig_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            bin_q      <= bus.Number_1;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ndig_q     <= 5'd20;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_CONVERT;
          end
        end

        S_CONVERT: begin
          bcd_q <= bcd_step(bcd_q, bin_q[63]);
          bin_q <= {bin_q[62:0], 1'b0};
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'd63) begin
            state_q <= S_SKIP;
          end
        end

        S_SKIP: begin
          if ((bcd_q[79:76] == 4'd0) && (ndig_q > 5'd1)) begin
            bcd_q  <= {bcd_q[75:0], 4'h0};
            ndig_q <= ndig_q - 5'd1;
          end else begin
            out_valid_q <= 1'b1;
            out_data_q  <= ascii_digit(bcd_q[79:76]);
            out_last_q  <= is_last(ndig_q);
            state_q     <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (bus.out_ready) begin
            if (ndig_q > 5'd1) begin
              bcd_q      <= {bcd_q[75:0], 4'h0};
              ndig_q     <= ndig_q - 5'd1;
              out_data_q <= ascii_digit(bcd_q[75:72]);
              out_last_q <= is_last(ndig_q - 5'd1);
            end else begin
`ifdef NUMOUT_NEWLINE_EN
              out_data_q <= 8'h0A;
              out_last_q <= 1'b1;
              state_q    <= S_NEWLINE;
`else
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= 8'h00;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
`endif
            end
          end
        end

`ifdef NUMOUT_NEWLINE_EN
        S_NEWLINE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 8'h00;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
`endif

        default: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_number_output_convertor.sv
// Self-checking bench for number_output_convertor. The reference model
// builds the expected byte string by repeated division by ten and derives
// the first-byte latency from the digit count.
module tb_number_output_convertor;

  logic clk = 1'b0;
  logic rst;

  number_output_convertor_if bus();

  number_output_convertor #(.UUID(0), .NAME("dut")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected bytes: decimal string of v, plus optional newline terminator.
  task automatic model(input logic [63:0] v, output int ndigits);
    logic [63:0] t;
    t = v;
    ndigits = 0;
    exp_q.delete();
    do begin
      exp_q.push_front(8'h30 + 8'(t % 64'd10));
      t = t / 64'd10;
      ndigits++;
    end while (t != 64'd0);
`ifdef NUMOUT_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  function automatic bit ready_pat(input int pat, input int k);
    if (pat == 0) return 1'b1;
    if (pat == 1) return (k % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Convert one number and check latency, byte stream, stalls and return to idle.
  // preset: value already presented with in_valid high (accept on next edge).
  // hold:   keep in_valid high with v2 after accept to test in_ready gating.
  task automatic run_number(input logic [63:0] v, input int pat, input bit preset,
                            input bit hold, input logic [63:0] v2);
    int nd, cyc, idx, k, guard;
    bit stalled;
    bit rdy;
    logic [7:0] stall_data;
    model(v, nd);
    if (!preset) begin
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 200) begin
        @(posedge clk); #1; guard++;
      end
      check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.Number_1 = v;
      bus.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    if (hold) begin
      bus.Number_1 = v2;
    end else begin
      bus.in_valid = 1'b0;
      bus.Number_1 = {32'($urandom), 32'($urandom)};
    end
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      check("in_ready_low_while_busy", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; cyc++;
    end
    check("first_valid_latency", 64'(cyc), 64'(65 + 20 - nd));
    idx = 0; k = 0; stalled = 1'b0; guard = 0; stall_data = 8'h00;
    while (idx < exp_q.size() && guard < 500) begin
      check("out_valid_held", 64'(bus.out_valid), 64'd1);
      if (stalled) check("stall_data_stable", 64'(bus.out_data), 64'(stall_data));
      rdy = ready_pat(pat, k);
      k++;
      bus.out_ready = rdy;
      if (rdy) begin
        check("out_data", 64'(bus.out_data), 64'(exp_q[idx]));
        check("out_last", 64'(bus.out_last), 64'(idx == exp_q.size() - 1));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        stall_data = bus.out_data;
      end
      @(posedge clk); #1; guard++;
    end
    check("all_bytes_taken", 64'(idx), 64'(exp_q.size()));
    check("in_ready_after_last", 64'(bus.in_ready), 64'd1);
    check("out_valid_after_last", 64'(bus.out_valid), 64'd0);
    check("busy_after_last", 64'(bus.busy), 64'd0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    logic [63:0] rv;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.Number_1 = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'h00);
    check("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed values
    run_number(64'd0, 0, 1'b0, 1'b0, 64'd0);
    run_number(64'd1234, 0, 1'b0, 1'b0, 64'd0);
    run_number(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 1'b0, 64'd0);
    run_number(64'd3330000, 1, 1'b0, 1'b0, 64'd0);
    run_number(64'd9, 0, 1'b0, 1'b0, 64'd0);
    run_number(64'd10, 1, 1'b0, 1'b0, 64'd0);

    // New value held on in_valid during conversion; accepted after the last byte
    run_number(64'd987654321, 2, 1'b0, 1'b1, 64'd42);
    run_number(64'd42, 0, 1'b1, 1'b0, 64'd0);

    // Reset pulsed mid-emission of 1234
    @(negedge clk);
    bus.Number_1 = 64'd1234;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check("rstmid_first_byte", 64'(bus.out_data), 64'h31);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("rstmid_second_byte", 64'(bus.out_data), 64'h32);
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rstmid_in_ready", 64'(bus.in_ready), 64'd1);
    check("rstmid_busy", 64'(bus.busy), 64'd0);
    check("rstmid_out_last", 64'(bus.out_last), 64'd0);
    check("rstmid_out_data", 64'(bus.out_data), 64'h00);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    run_number(64'd56, 0, 1'b0, 1'b0, 64'd0);

    // Random values of random magnitude with random back-pressure
    for (int i = 0; i < 8; i++) begin
      rv = {32'($urandom), 32'($urandom)};
      rv = rv >> $urandom_range(0, 63);
      run_number(rv, 2, 1'b0, 1'b0, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
